bus_response_collector: RTL and testbench

Return-path companion to the memory decoder: the decoder fans a CPU request out to one of eight device enables, and this block carries the reply back. It latches the decoded enable at request start, gates a per-device valid, waits for that device's ready, and returns one registered ready/rdata beat to the CPU. Unmapped, multiply-decoded, or timed-out accesses complete with an error beat, so the core never hangs.

---
 rtl/bus_pkg.sv | 34 +++
 rtl/onehot_mux.sv | 33 +++
 rtl/bus_response_collector.sv | 121 ++++++++++++
 tb/tb_bus_response_collector.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - shared types, defaults and one-hot classifier for the bus return path
// Purpose: state encoding, default slot count, error data word and a
//          one-hot classification helper shared with the decoder bench.
// Ports:   none (package)
package bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    OH_ZERO   = 2'd0,
    OH_SINGLE = 2'd1,
    OH_MULTI  = 2'd2
  } onehot_e;

  localparam int          NDEV_DEFAULT     = 8;
  localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEADBEEF;

  // Classifies an enable vector (zero-extended to 32 bits by the caller).
  // v & (v-1) clears the lowest set bit, so it is zero only for a single hit.
  function automatic onehot_e onehot_check(input logic [31:0] v);
    if (v == 32'd0) begin
      return OH_ZERO;
    end else if ((v & (v - 32'd1)) == 32'd0) begin
      return OH_SINGLE;
    end else begin
      return OH_MULTI;
    end
  endfunction

endpackage

// File: rtl/onehot_mux.sv
// rtl/onehot_mux.sv - one-hot indexed data and ready select for the device slots
// Purpose: picks the read data and ready strobe of the slot named by a
//          one-hot select; an all-zero select yields zero data and no ready.
// Ports:   sel_i        one-hot slot select
//          dev_ready_i  per-slot ready strobes
//          dev_rdata_i  per-slot read data, slot i at [32*i+31:32*i]
//          rdata_o      data of the selected slot
//          ready_o      ready of the selected slot
module onehot_mux
  import bus_pkg::*;
#(
  parameter int NDEV = NDEV_DEFAULT
) (
  input  logic [NDEV-1:0]    sel_i,
  input  logic [NDEV-1:0]    dev_ready_i,
  input  logic [NDEV*32-1:0] dev_rdata_i,
  output logic [31:0]        rdata_o,
  output logic               ready_o
);

  // AND-OR mux: correct for one-hot select, no priority chain needed.
  always_comb begin
    rdata_o = 32'd0;
    for (int i = 0; i < NDEV; i++) begin
      if (sel_i[i]) begin
        rdata_o = rdata_o | dev_rdata_i[32*i +: 32];
      end
    end
  end

  assign ready_o = |(sel_i & dev_ready_i);

endmodule

// File: rtl/bus_response_collector.sv
// rtl/bus_response_collector.sv - collects the selected device reply and returns one beat to the CPU
// Purpose: latches the decoded enable, strobes the selected device, waits
//          for its ready (bounded by TIMEOUT) and returns a registered
//          ready/rdata/error beat. Bad decodes and timeouts return ERR_DATA.
// Ports:   clk, reset   clock, asynchronous active-high reset
//          mem_valid    CPU request strobe, held until mem_ready
//          enables      decoder one-hot slot enables
//          dev_ready    per-device completion strobes
//          dev_rdata    per-device read data, slot i at [32*i+31:32*i]
//          dev_valid    per-device request strobe (selected slot in WAIT)
//          mem_ready    one-cycle completion pulse
//          mem_rdata    returned read data
//          bus_error    1 when the completion is an error beat
module bus_response_collector
  import bus_pkg::*;
#(
  parameter int          NDEV     = NDEV_DEFAULT,
  parameter int          TIMEOUT  = 255,
  parameter logic [31:0] ERR_DATA = ERR_DATA_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               mem_valid,
  input  logic [NDEV-1:0]    enables,
  input  logic [NDEV-1:0]    dev_ready,
  input  logic [NDEV*32-1:0] dev_rdata,
  output logic [NDEV-1:0]    dev_valid,
  output logic               mem_ready,
  output logic [31:0]        mem_rdata,
  output logic               bus_error
);

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

  state_e            state_q;
  logic [NDEV-1:0]   sel_q;
  logic [15:0]       cnt_q;
  logic              mem_ready_q;
  logic [31:0]       mem_rdata_q;
  logic              bus_error_q;

  logic [31:0]       sel_rdata;
  logic              sel_ready;
  onehot_e           dec_kind;

  // NDEV is at most 32, so zero-extension keeps the classification exact.
  assign dec_kind = onehot_check(32'(enables));

  onehot_mux #(
    .NDEV(NDEV)
  ) u_mux (
    .sel_i      (sel_q),
    .dev_ready_i(dev_ready),
    .dev_rdata_i(dev_rdata),
    .rdata_o    (sel_rdata),
    .ready_o    (sel_ready)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      sel_q       <= '0;
      cnt_q       <= 16'd0;
      mem_ready_q <= 1'b0;
      mem_rdata_q <= 32'd0;
      bus_error_q <= 1'b0;
    end else begin
      mem_ready_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (mem_valid) begin
            if (dec_kind == OH_SINGLE) begin
              sel_q   <= enables;
              cnt_q   <= 16'd0;
              state_q <= ST_WAIT;
            end else begin
              // Unmapped or multiply-decoded: no device is ever strobed.
              mem_rdata_q <= ERR_DATA;
              bus_error_q <= 1'b1;
              mem_ready_q <= 1'b1;
              state_q     <= ST_DONE;
            end
          end
        end
        ST_WAIT: begin
          if (!mem_valid) begin
            sel_q   <= '0;
            state_q <= ST_IDLE;
          end else if (sel_ready) begin
            // Checked before the timeout so a last-cycle ready still succeeds.
            mem_rdata_q <= sel_rdata;
            bus_error_q <= 1'b0;
            mem_ready_q <= 1'b1;
            state_q     <= ST_DONE;
          end else if (cnt_q == CNT_LAST) begin
            mem_rdata_q <= ERR_DATA;
            bus_error_q <= 1'b1;
            mem_ready_q <= 1'b1;
            state_q     <= ST_DONE;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        ST_DONE: begin
          sel_q   <= '0;
          state_q <= ST_IDLE;
        end
        default: begin
          sel_q   <= '0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign dev_valid = (state_q == ST_WAIT) ? sel_q : '0;
  assign mem_ready = mem_ready_q;
  assign mem_rdata = mem_rdata_q;
  assign bus_error = bus_error_q;

endmodule

// File: tb/tb_bus_response_collector.sv
// tb/tb_bus_response_collector.sv - directed and randomized bench for bus_response_collector
module tb_bus_response_collector;

  localparam int          NDEV    = 8;
  localparam int          TIMEOUT = 4;
  localparam logic [31:0] ERR     = 32'hDEADBEEF;

  logic               clk = 1'b0;
  logic               reset;
  logic               mem_valid;
  logic [NDEV-1:0]    enables;
  logic [NDEV-1:0]    dev_ready;
  logic [NDEV*32-1:0] dev_rdata;
  logic [NDEV-1:0]    dev_valid;
  logic               mem_ready;
  logic [31:0]        mem_rdata;
  logic               bus_error;

  int checks = 0;
  int errors = 0;
  bit in_done = 1'b0;

  bus_response_collector #(
    .NDEV    (NDEV),
    .TIMEOUT (TIMEOUT),
    .ERR_DATA(ERR)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .mem_valid(mem_valid),
    .enables  (enables),
    .dev_ready(dev_ready),
    .dev_rdata(dev_rdata),
    .dev_valid(dev_valid),
    .mem_ready(mem_ready),
    .mem_rdata(mem_rdata),
    .bus_error(bus_error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive_rdata(input bit use_fix, input logic [31:0] fix);
    for (int i = 0; i < NDEV; i++) begin
      dev_rdata[32*i +: 32] = use_fix ? fix : $urandom;
    end
  endtask

  // Reference: a transaction completes c edges after E0, where c is 0 for a
  // bad decode, 1+k when the selected device answers k cycles into WAIT
  // before the budget runs out, and TIMEOUT otherwise.
  task automatic run_txn(input logic [NDEV-1:0] en, input int k, input bit noise,
                         input bit b2b, input bit use_fix, input logic [31:0] fix);
    int          c;
    int          sel;
    bit          single;
    logic [31:0] exp_data;
    logic        exp_err;
    single = ($countones(en) == 1);
    sel = 0;
    for (int i = 0; i < NDEV; i++) if (en[i]) sel = i;
    if (!single) begin
      c = 0; exp_err = 1'b1; exp_data = ERR;
    end else if (k <= TIMEOUT - 1) begin
      c = 1 + k; exp_err = 1'b0; exp_data = 32'hx;
    end else begin
      c = TIMEOUT; exp_err = 1'b1; exp_data = ERR;
    end
    mem_valid = 1'b1;
    enables   = en;
    if (in_done) begin
      @(posedge clk); @(negedge clk);
      check("gap_mem_ready", mem_ready, 32'd0);
      check("gap_dev_valid", dev_valid, 32'd0);
    end
    dev_ready = noise ? NDEV'($urandom) : '0;
    drive_rdata(use_fix, fix);
    for (int j = 0; j <= c; j++) begin
      @(posedge clk); @(negedge clk);
      check("mem_ready", mem_ready, (j == c) ? 32'd1 : 32'd0);
      check("dev_valid", dev_valid, (single && j < c) ? 32'(en) : 32'd0);
      if (j == c) begin
        check("bus_error", bus_error, 32'(exp_err));
        check("mem_rdata", mem_rdata, exp_data);
      end
      dev_ready = noise ? NDEV'($urandom) : '0;
      if (single) dev_ready[sel] = (j == k);
      drive_rdata(use_fix, fix);
      if (single && j == k && !exp_err) exp_data = dev_rdata[32*sel +: 32];
    end
    dev_ready = '0;
    if (b2b) begin
      in_done = 1'b1;
    end else begin
      mem_valid = 1'b0;
      enables   = '0;
      @(posedge clk); @(negedge clk);
      check("hold_mem_ready", mem_ready, 32'd0);
      check("hold_mem_rdata", mem_rdata, exp_data);
      check("hold_bus_error", bus_error, 32'(exp_err));
      in_done = 1'b0;
    end
  endtask

  initial begin
    logic [NDEV-1:0] en;
    int              a;
    int              b;
    int              r;
    reset     = 1'b1;
    mem_valid = 1'b0;
    enables   = '0;
    dev_ready = '0;
    dev_rdata = '0;
    repeat (2) @(negedge clk);
    check("rst_dev_valid", dev_valid, 32'd0);
    check("rst_mem_ready", mem_ready, 32'd0);
    check("rst_mem_rdata", mem_rdata, 32'd0);
    check("rst_bus_error", bus_error, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Normal read: ready at E3, fixed data.
    run_txn(8'h01, 2, 1'b0, 1'b0, 1'b1, 32'h12345678);
    // Unmapped and multi-decode.
    run_txn(8'h00, 0, 1'b0, 1'b0, 1'b0, 32'd0);
    run_txn(8'h05, 0, 1'b1, 1'b0, 1'b0, 32'd0);
    // Timeout on slot 2, then ready exactly at E(TIMEOUT).
    run_txn(8'h04, 100, 1'b0, 1'b0, 1'b0, 32'd0);
    run_txn(8'h04, TIMEOUT - 1, 1'b0, 1'b0, 1'b0, 32'd0);

    // Wrong-slot ready then abort.
    mem_valid = 1'b1; enables = 8'h08; dev_ready = '0;
    @(posedge clk); @(negedge clk);
    check("abort_dev_valid0", dev_valid, 32'h08);
    dev_ready = 8'h20;
    @(posedge clk); @(negedge clk);
    check("wrong_slot_ready", mem_ready, 32'd0);
    check("abort_dev_valid1", dev_valid, 32'h08);
    mem_valid = 1'b0; enables = '0; dev_ready = '0;
    @(posedge clk); @(negedge clk);
    check("abort_dev_valid2", dev_valid, 32'd0);
    check("abort_mem_ready0", mem_ready, 32'd0);
    @(posedge clk); @(negedge clk);
    check("abort_mem_ready1", mem_ready, 32'd0);

    // Randomized transactions, some back to back.
    for (int n = 0; n < 30; n++) begin
      r = $urandom_range(0, 9);
      a = $urandom_range(0, NDEV - 1);
      if (r < 7) begin
        en = NDEV'(1) << a;
      end else if (r == 7) begin
        en = '0;
      end else begin
        b  = (a + 1 + $urandom_range(0, NDEV - 2)) % NDEV;
        en = (NDEV'(1) << a) | (NDEV'(1) << b);
      end
      run_txn(en, $urandom_range(0, TIMEOUT + 1), 1'b1,
              (n < 29) ? bit'($urandom_range(0, 1)) : 1'b0, 1'b0, 32'd0);
    end

    // Reset mid-WAIT after an error beat left nonzero read data.
    run_txn(8'h00, 0, 1'b0, 1'b0, 1'b0, 32'd0);
    mem_valid = 1'b1; enables = 8'h02;
    @(posedge clk); @(negedge clk);
    check("pre_rst_dev_valid", dev_valid, 32'h02);
    #2 reset = 1'b1;
    #1;
    check("async_rst_dev_valid", dev_valid, 32'd0);
    check("async_rst_mem_ready", mem_ready, 32'd0);
    check("async_rst_mem_rdata", mem_rdata, 32'd0);
    check("async_rst_bus_error", bus_error, 32'd0);
    mem_valid = 1'b0; enables = '0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    run_txn(8'h80, 1, 1'b0, 1'b0, 1'b0, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
